// File: rtl/secuencia_generador_pkg.sv
// Shared types and helpers for the serial pattern generator and its detector peer.
// Provides the FSM state encoding, the default idle line level and a constant clog2.
package secuencia_generador_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_FIN  = 2'd2
  } sg_state_t;

  localparam logic IDLE_LEVEL_DEF = 1'b0;

  // Never returns less than 1 so it can size a counter for any value.
  function automatic int sg_clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/secuencia_tick.sv
// Bit-time prescaler: counts 0..DIV-1 while enabled and pulses tick on terminal count.
// clr has priority over en and returns the count to zero.
module secuencia_tick
  import secuencia_generador_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = sg_clog2(DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          terminal;

  assign terminal = (cnt_q == CW'(DIV - 1));
  assign tick     = en & terminal;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = terminal ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/secuencia_generador.sv
// Serial pattern transmitter: shifts a LEN-bit pattern out on w, MSB first, DIV cycles per bit,
// then pulses done. SECUENCIA_GEN_PARITY_EN appends one even-parity bit time to every frame.
module secuencia_generador
  import secuencia_generador_pkg::*;
#(
  parameter int             LEN        = 4,
  parameter logic [LEN-1:0] PATTERN    = 4'b1011,
  parameter int             DIV        = 1,
  parameter logic           IDLE_LEVEL = IDLE_LEVEL_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          load,
  input  logic [LEN-1:0]                pat_in,
  output logic                          w,
  output logic                          busy,
  output logic                          done,
  output logic [sg_clog2(LEN+1)-1:0]    bit_idx
);

  localparam int IDX_W = sg_clog2(LEN + 1);
`ifdef SECUENCIA_GEN_PARITY_EN
  localparam int FRAME_BITS = LEN + 1;
`else
  localparam int FRAME_BITS = LEN;
`endif

  sg_state_t      state_q, state_d;
  logic [LEN-1:0] pat_q, pat_d;
  logic [LEN-1:0] shreg_q, shreg_d;
  logic           w_q, w_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic           tick;
`ifdef SECUENCIA_GEN_PARITY_EN
  logic           par_q, par_d;
`endif

  // With DIV=1 every SEND cycle is a bit boundary, so no prescaler is built.
  generate
    if (DIV > 1) begin : g_presc
      secuencia_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .rst_n (reset),
        .en    (state_q == S_SEND),
        .clr   (state_q != S_SEND),
        .tick  (tick)
      );
    end else begin : g_no_presc
      assign tick = 1'b1;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    shreg_d = shreg_q;
    w_d     = w_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    idx_d   = idx_q;
`ifdef SECUENCIA_GEN_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        w_d    = IDLE_LEVEL;
        busy_d = 1'b0;
        idx_d  = '0;
        if (load) pat_d = pat_in;
        // The frame launches from the pattern held before any same-cycle load.
        if (start) begin
          state_d = S_SEND;
          shreg_d = pat_q;
          w_d     = pat_q[LEN-1];
          busy_d  = 1'b1;
`ifdef SECUENCIA_GEN_PARITY_EN
          par_d   = ^pat_q;
`endif
        end
      end
      S_SEND: begin
        if (tick) begin
          if (idx_q == IDX_W'(FRAME_BITS - 1)) begin
            state_d = S_FIN;
            w_d     = IDLE_LEVEL;
            busy_d  = 1'b0;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            shreg_d = shreg_q << 1;
            idx_d   = idx_q + IDX_W'(1);
            w_d     = shreg_q[LEN-2];
`ifdef SECUENCIA_GEN_PARITY_EN
            if (idx_q == IDX_W'(LEN - 1)) w_d = par_q;
`endif
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        w_d     = IDLE_LEVEL;
        busy_d  = 1'b0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pat_q   <= PATTERN;
      shreg_q <= '0;
      w_q     <= IDLE_LEVEL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
`ifdef SECUENCIA_GEN_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      shreg_q <= shreg_d;
      w_q     <= w_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
`ifdef SECUENCIA_GEN_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign w       = w_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign bit_idx = idx_q;

endmodule

// File: tb/tb_secuencia_generador.sv
// Directed bench for secuencia_generador: default instance (DIV=1) and a DIV=3 instance.
// Parity expectations switch with SECUENCIA_GEN_PARITY_EN.
module tb_secuencia_generador;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       load;
  logic [3:0] pat_in;

  logic       w, busy, done;
  logic [2:0] bit_idx;
  logic       w3, busy3, done3;
  logic [2:0] bit_idx3;

  int checks = 0;
  int failures = 0;

`ifdef SECUENCIA_GEN_PARITY_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  always #5 clk = ~clk;

  secuencia_generador u_dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .load    (load),
    .pat_in  (pat_in),
    .w       (w),
    .busy    (busy),
    .done    (done),
    .bit_idx (bit_idx)
  );

  secuencia_generador #(.DIV(3)) u_div3 (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .load    (load),
    .pat_in  (pat_in),
    .w       (w3),
    .busy    (busy3),
    .done    (done3),
    .bit_idx (bit_idx3)
  );

  typedef struct {
    logic       start;
    logic       load;
    logic [3:0] pat_in;
    logic       exp_w;
    logic       exp_busy;
    logic       exp_done;
    logic [2:0] exp_idx;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic s, input logic l, input logic [3:0] p,
                              input logic ew, input logic eb, input logic ed,
                              input logic [2:0] ei);
    vec_t v;
    v.start = s; v.load = l; v.pat_in = p;
    v.exp_w = ew; v.exp_busy = eb; v.exp_done = ed; v.exp_idx = ei;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string nm, input logic ew, input logic eb,
                         input logic ed, input logic [2:0] ei);
    chk({nm, ".w"},       {7'd0, w},       {7'd0, ew});
    chk({nm, ".busy"},    {7'd0, busy},    {7'd0, eb});
    chk({nm, ".done"},    {7'd0, done},    {7'd0, ed});
    chk({nm, ".bit_idx"}, {5'd0, bit_idx}, {5'd0, ei});
  endtask

  task automatic tick_cycle();
    @(posedge clk);
    #1;
  endtask

  // Full frame on the DIV=1 instance; optionally pokes start/load(0000) while bit 2 is on the line.
  task automatic run_frame(input string nm, input logic [3:0] p, input logic par,
                           input logic inject);
    logic [4:0] bits;
    bits = {p, par};
    start = 1'b1;
    tick_cycle();
    start = 1'b0;
    for (int i = 0; i < NB; i++) begin
      chk_out(nm, bits[4-i], 1'b1, 1'b0, 3'(i));
      if (inject && i == 2) begin
        start = 1'b1; load = 1'b1; pat_in = 4'b0000;
      end
      tick_cycle();
      start = 1'b0; load = 1'b0;
    end
    chk_out({nm, "_done"}, 1'b0, 1'b0, 1'b1, 3'd0);
    for (int i = 0; i < 3; i++) begin
      tick_cycle();
      chk_out({nm, "_after"}, 1'b0, 1'b0, 1'b0, 3'd0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick_cycle();
    reset = 1'b1;
    tick_cycle();
  endtask

  initial begin
    logic [4:0] frame3;

    reset = 1'b0; start = 1'b0; load = 1'b0; pat_in = 4'd0;

    // Test 1: default pattern 1011, one bit per cycle.
    tbl.push_back(mk(1, 0, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 4'h0, 1, 1, 0, 2));
    tbl.push_back(mk(0, 0, 4'h0, 1, 1, 0, 3));
`ifdef SECUENCIA_GEN_PARITY_EN
    tbl.push_back(mk(0, 0, 4'h0, 1, 1, 0, 4));
`endif
    tbl.push_back(mk(0, 0, 4'h0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 4'h0, 0, 0, 0, 0));
    // Test 2: load 0110 in idle, then two back-to-back frames.
    tbl.push_back(mk(0, 1, 4'h6, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 4'h0, 1, 1, 0, 2));
    tbl.push_back(mk(0, 0, 4'h0, 0, 1, 0, 3));
`ifdef SECUENCIA_GEN_PARITY_EN
    tbl.push_back(mk(0, 0, 4'h0, 0, 1, 0, 4));
`endif
    tbl.push_back(mk(0, 0, 4'h0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 4'h0, 1, 1, 0, 2));
    tbl.push_back(mk(0, 0, 4'h0, 0, 1, 0, 3));
`ifdef SECUENCIA_GEN_PARITY_EN
    tbl.push_back(mk(0, 0, 4'h0, 0, 1, 0, 4));
`endif
    tbl.push_back(mk(0, 0, 4'h0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 4'h0, 0, 0, 0, 0));

    // Reset state.
    tick_cycle();
    tick_cycle();
    chk_out("reset", 1'b0, 1'b0, 1'b0, 3'd0);
    chk("reset3.busy", {7'd0, busy3}, 8'd0);
    reset = 1'b1;

    foreach (tbl[k]) begin
      start = tbl[k].start; load = tbl[k].load; pat_in = tbl[k].pat_in;
      chk_out($sformatf("vec%0d", k), tbl[k].exp_w, tbl[k].exp_busy,
              tbl[k].exp_done, tbl[k].exp_idx);
      tick_cycle();
    end
    start = 1'b0; load = 1'b0; pat_in = 4'd0;

    // Test 3: DIV=3, each bit held three cycles, done after the last bit time.
    do_reset();
    frame3 = 5'b10111;
    start = 1'b1;
    tick_cycle();
    start = 1'b0;
    for (int c = 1; c <= NB * 3; c++) begin
      chk($sformatf("div3.w.c%0d", c),    {7'd0, w3},       {7'd0, frame3[4 - (c - 1) / 3]});
      chk($sformatf("div3.busy.c%0d", c), {7'd0, busy3},    8'd1);
      chk($sformatf("div3.idx.c%0d", c),  {5'd0, bit_idx3}, 8'((c - 1) / 3));
      chk($sformatf("div3.done.c%0d", c), {7'd0, done3},    8'd0);
      tick_cycle();
    end
    chk("div3.done_pulse", {7'd0, done3}, 8'd1);
    chk("div3.busy_end",   {7'd0, busy3}, 8'd0);
    chk("div3.w_end",      {7'd0, w3},    8'd0);
    tick_cycle();
    chk("div3.done_clear", {7'd0, done3}, 8'd0);
    tick_cycle();

    // Test 4: start/load during SEND are ignored; pattern stays 1011.
    do_reset();
    run_frame("inject", 4'b1011, 1'b1, 1'b1);
    run_frame("after_inject", 4'b1011, 1'b1, 1'b0);

    // Test 5: asynchronous reset mid-frame aborts without done.
    start = 1'b1;
    tick_cycle();
    start = 1'b0;
    tick_cycle();
    tick_cycle();
    chk("abort.idx_before", {5'd0, bit_idx}, 8'd2);
    #2;
    reset = 1'b0;
    #1;
    chk_out("abort_async", 1'b0, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 2; i++) begin
      tick_cycle();
      chk_out("abort_held", 1'b0, 1'b0, 1'b0, 3'd0);
    end
    reset = 1'b1;
    tick_cycle();
    chk_out("abort_release", 1'b0, 1'b0, 1'b0, 3'd0);
    run_frame("post_reset", 4'b1011, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/secuencia_generador.md
Name: secuencia_generador

Overview:
Serial bit-pattern transmitter. It is the driving end of the single-bit `w` line consumed by the Moore sequence detector, `secuencia_moore`.
- On a start request it shifts a LEN-bit pattern out on `w`, MSB first, holding each bit for DIV clock cycles.
- It then pulses `done` and returns to idle.
- It replaces hand-written `w` stimulus in detector benches and on-board demos (EDU-CIAA).

Parameters:
LEN, 4, pattern length in bits (>=2)
PATTERN, 4'b1011, reset value of the internal pattern register (LEN bits)
DIV, 1, clock cycles per bit time (>=1)
IDLE_LEVEL, 1'b0, value driven on `w` when not transmitting

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  transmit request, sampled in IDLE only
load  input  1  write `pat_in` into the pattern register, honoured in IDLE only
pat_in  input  LEN  new pattern value
w  output  1  serial bit stream, registered
busy  output  1  high while a frame is in progress
done  output  1  one-cycle pulse after the last bit time
bit_idx  output  clog2(LEN+1)  index of the bit currently driven (0 = MSB), 0 when idle

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, w=IDLE_LEVEL, busy=0, done=0, bit_idx=0.
  - Pattern register=PATTERN; prescaler and bit counter cleared.
  - Reset asserted mid-frame aborts the frame immediately; no `done` pulse.
- FSM states IDLE, SEND, FIN; two-bit encoding.
- IDLE:
  - w=IDLE_LEVEL.
  - load=1 → pattern register <= pat_in on the next edge.
  - start=1 → next edge: shift register <= pattern register, state SEND, busy=1, w=MSB, bit_idx=0.
  - load and start high in the same cycle: start uses the OLD pattern; the new pattern is stored for the next frame.
- SEND:
  - Prescaler counts 0..DIV-1; on terminal count it shifts left, increments bit_idx, and w takes the next bit.
  - After bit LEN-1 has been held for DIV cycles: state FIN, w=IDLE_LEVEL, busy=0.
  - start and load are ignored (no queuing).
- FIN: done=1 for exactly one cycle, then IDLE. start in FIN is ignored.
- Latency: start sampled at edge N → first bit on w from edge N+1. Frame occupies LEN*DIV cycles. done is high during cycle N+1+LEN*DIV.
- DIV=1: prescaler is removed by generate; one bit per cycle.
- All outputs come from flops; no combinational path from inputs to outputs.

Optional Feature:
Macro SECUENCIA_GEN_PARITY_EN.
- Defined: after the LEN data bits, one extra bit time carries even parity (XOR of the transmitted pattern). busy spans (LEN+1)*DIV cycles, bit_idx reaches LEN during the parity bit, and done follows the parity bit.
- Undefined: no parity bit and no parity logic is synthesized.

Decomposition:
- Shared include `secuencia_defs.vh`:
  - state localparams S_IDLE/S_SEND/S_FIN;
  - IDLE_LEVEL default;
  - clog2 constant function.
- `secuencia_moore` uses the same include.
- One natural sub-module, `secuencia_tick`: a DIV prescaler with enable and clear that outputs a one-cycle `tick` on terminal count.

Test Plan:
1. Defaults (LEN=4, PATTERN=1011, DIV=1); start pulse at cycle 0 → w=1,0,1,1 in cycles 1-4; busy=1 in cycles 1-4; done=1 in cycle 5; w=0 from cycle 5.
2. load=1 with pat_in=0110 in IDLE, then start → w=0,1,1,0. A second start without load → 0,1,1,0 again.
3. DIV=3 → each bit held 3 cycles; busy high 12 cycles; done at cycle 13 after start.
4. start pulsed at bit_idx=2 and load=1 with pat_in=0000 during SEND → frame unchanged (1011), one done pulse, pattern register still 1011.
5. reset=0 asserted at bit_idx=2 → w=0, busy=0, done=0 asynchronously, no done pulse. After release, start → 1011 (PATTERN restored).
6. SECUENCIA_GEN_PARITY_EN defined, pattern 1011 → w=1,0,1,1,1 (parity bit 1); done in cycle 6. Pattern 0110 → parity bit 0.
